// File: rtl/dram_arbiter.sv
// Round-robin arbiter that serialises per-core read/write requests onto one shared DRAM port.
// Optional macro DRAM_ARB_FIXED_PRIO_EN replaces round-robin with fixed priority (core 0 highest).
module dram_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        req_wren,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_wren,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy
);
    localparam int PTR_W = (NUM_CORES > 2) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT, ACK} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   winIdx_q, winIdx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               wren_q, wren_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
`ifndef DRAM_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]   ptr_q, ptr_d;
`endif

    logic [ADDR_W-1:0]  coreAddr  [NUM_CORES];
    logic [DATA_W-1:0]  coreWdata [NUM_CORES];
    logic               found;
    logic [PTR_W-1:0]   selIdx;
    logic [PTR_W-1:0]   cand;

    for (genvar g = 0; g < NUM_CORES; g++) begin : gUnpack
        assign coreAddr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign coreWdata[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // Winner search: first set request starting at the pointer (or at core 0), with wrap.
    always_comb begin
        found  = 1'b0;
        selIdx = '0;
        cand   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
            cand = PTR_W'(i);
`else
            cand = PTR_W'((int'(ptr_q) + i) % NUM_CORES);
`endif
            if (!found && req[cand]) begin
                found  = 1'b1;
                selIdx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        winIdx_d = winIdx_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wren_d   = wren_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
`ifndef DRAM_ARB_FIXED_PRIO_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    winIdx_d = selIdx;
                    addr_d   = coreAddr[selIdx];
                    wdata_d  = coreWdata[selIdx];
                    wren_d   = req_wren[selIdx];
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (wren_q) begin
                    state_d = ACK;
                end else begin
                    cnt_d   = CNT_W'(RD_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = mem_rdata;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
`ifndef DRAM_ARB_FIXED_PRIO_EN
                ptr_d = PTR_W'((int'(winIdx_q) + 1) % NUM_CORES);
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            winIdx_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wren_q   <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            winIdx_q <= winIdx_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wren_q   <= wren_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    // Address, write data and read data hold their last values while idle.
    always_comb begin
        gnt = '0;
        ack = '0;
        if (state_q != IDLE) gnt[winIdx_q] = 1'b1;
        if (state_q == ACK)  ack[winIdx_q] = 1'b1;
    end

    assign mem_wren  = (state_q == GRANT) && wren_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: transaction-level model compared every cycle plus directed literal checks.
// Honours DRAM_ARB_FIXED_PRIO_EN when the design is built with it.
module tb_dram_arbiter;
    localparam int NC  = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int RDL = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NC-1:0]     req = '0;
    logic [NC-1:0]     req_wren = '0;
    logic [NC*AW-1:0]  req_addr = '0;
    logic [NC*DW-1:0]  req_wdata = '0;
    logic [DW-1:0]     mem_rdata;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_wren;
    logic [NC-1:0]     gnt;
    logic [NC-1:0]     ack;
    logic [DW-1:0]     rdata;
    logic              busy;

    int compared   = 0;
    int mismatched = 0;

    dram_arbiter #(
        .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_wren(req_wren),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Unwritten locations return a fixed pattern; 0x11 is preset for the directed read.
    function automatic logic [DW-1:0] defaultData(input logic [7:0] a);
        return (a == 8'h11) ? 16'h1234 : {a, ~a};
    endfunction

    // DRAM model with RDL-cycle read pipeline.
    logic [DW-1:0] envMem     [256];
    bit            envWritten [256];
    logic [DW-1:0] rdPipe     [RDL];

    always @(posedge clk) begin
        if (mem_wren) begin
            envMem[mem_addr[7:0]]     <= mem_wdata;
            envWritten[mem_addr[7:0]] <= 1'b1;
        end
        rdPipe[0] <= envWritten[mem_addr[7:0]] ? envMem[mem_addr[7:0]] : defaultData(mem_addr[7:0]);
        for (int i = 1; i < RDL; i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign mem_rdata = rdPipe[RDL-1];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one active transaction, position kM cycles after the sampling cycle.
    int             ptrM, winM, kM, lastK, idxM;
    bit             activeM, wrM, pickedM;
    logic [AW-1:0]  addrM, heldAddrM;
    logic [DW-1:0]  dataM, heldDataM, heldRdM;
    logic [DW-1:0]  modelMem [int];
    logic [NC-1:0]  expGnt, expAck;
    logic           expWren, expBusy;
    logic [DW-1:0]  expRd;

    function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a);
        if (modelMem.exists(int'(a[7:0]))) return modelMem[int'(a[7:0])];
        return defaultData(a[7:0]);
    endfunction

    task automatic resetModel();
        ptrM = 0; activeM = 1'b0; winM = 0; kM = 0; wrM = 1'b0;
        addrM = '0; dataM = '0; heldAddrM = '0; heldDataM = '0; heldRdM = '0;
    endtask

    initial begin : scoreboard
        resetModel();
        forever begin
            @(negedge clk);
            if (!rst_n) resetModel();
            lastK   = wrM ? 2 : 2 + RDL;
            expGnt  = '0;
            expAck  = '0;
            expWren = 1'b0;
            expBusy = 1'b0;
            expRd   = heldRdM;
            if (activeM) begin
                expGnt[winM] = 1'b1;
                expBusy      = 1'b1;
                expWren      = wrM && (kM == 1);
                if (kM == lastK) begin
                    expAck[winM] = 1'b1;
                    if (!wrM) expRd = modelRead(addrM);
                end
            end
            checkOutput("gnt", gnt, expGnt);
            checkOutput("ack", ack, expAck);
            checkOutput("memWren", mem_wren, expWren);
            checkOutput("busy", busy, expBusy);
            checkOutput("memAddr", mem_addr, heldAddrM);
            checkOutput("memWdata", mem_wdata, heldDataM);
            checkOutput("rdata", rdata, expRd);
            if (rst_n) begin
                if (activeM) begin
                    if (kM == lastK) begin
                        activeM = 1'b0;
                        heldRdM = expRd;
                        ptrM    = (winM + 1) % NC;
                    end else begin
                        kM++;
                    end
                end else if (req != '0) begin
                    pickedM = 1'b0;
                    for (int j = 0; j < NC; j++) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
                        idxM = j;
`else
                        idxM = (ptrM + j) % NC;
`endif
                        if (!pickedM && req[idxM]) begin
                            winM    = idxM;
                            pickedM = 1'b1;
                        end
                    end
                    addrM     = req_addr[winM*AW +: AW];
                    dataM     = req_wdata[winM*DW +: DW];
                    wrM       = req_wren[winM];
                    if (wrM) modelMem[int'(addrM[7:0])] = dataM;
                    heldAddrM = addrM;
                    heldDataM = dataM;
                    activeM   = 1'b1;
                    kM        = 1;
                end
            end
        end
    end

    logic [NC-1:0] gntLog [$];
    logic [NC-1:0] rrExp  [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int core, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wren[core]            = wr;
        req_addr[core*AW +: AW]   = a;
        req_wdata[core*DW +: DW]  = d;
        req[core]                 = 1'b1;
    endtask

    task automatic collectGrants(input int n, input bit autoDrop, input int maxCycles);
        int  cycles = 0;
        bit  prevBusy = busy;
        gntLog.delete();
        while (gntLog.size() < n && cycles < maxCycles) begin
            tick();
            cycles++;
            if (autoDrop) req = req & ~ack;
            if (busy && !prevBusy) gntLog.push_back(gnt);
            prevBusy = busy;
        end
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        while (busy && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("idleReached", busy, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstGnt", gnt, 0);
        checkOutput("rstAck", ack, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstWren", mem_wren, 0);
        checkOutput("rstAddr", mem_addr, 0);
        checkOutput("rstRdata", rdata, 0);
        rst_n = 1'b1;
        tick();

        // Single write from core 1.
        applyStimulus(1, 1'b1, 16'h0040, 16'hBEEF);
        checkOutput("wrIdleBusy", busy, 0);
        tick();
        checkOutput("wrGrantWren", mem_wren, 1);
        checkOutput("wrGrantAddr", mem_addr, 16'h0040);
        checkOutput("wrGrantData", mem_wdata, 16'hBEEF);
        checkOutput("wrGrantGnt", gnt, 4'b0010);
        checkOutput("wrGrantBusy", busy, 1);
        tick();
        checkOutput("wrAck", ack, 4'b0010);
        checkOutput("wrAckWren", mem_wren, 0);
        checkOutput("wrAckBusy", busy, 1);
        req = '0;
        tick();
        checkOutput("wrDoneBusy", busy, 0);
        checkOutput("wrHeldAddr", mem_addr, 16'h0040);
        checkOutput("wrHeldData", mem_wdata, 16'hBEEF);

        // Single read from core 3, ack lands at cycle +4 with RD_LATENCY=2.
        applyStimulus(3, 1'b0, 16'h0011, 16'h0000);
        for (int c = 1; c <= 3; c++) begin
            tick();
            checkOutput("rdNoWren", mem_wren, 0);
            checkOutput("rdNoAck", ack, 0);
        end
        tick();
        checkOutput("rdAck", ack, 4'b1000);
        checkOutput("rdData", rdata, 16'h1234);
        req = '0;
        tick();

        // All four cores hold write requests.
        for (int i = 0; i < NC; i++) applyStimulus(i, 1'b1, 16'h0050 + 16'(i), 16'hA000 + 16'(i));
`ifdef DRAM_ARB_FIXED_PRIO_EN
        rrExp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        rrExp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        collectGrants(5, 1'b0, 40);
        req = '0;
        waitIdle(10);
        checkOutput("rrCount", gntLog.size(), 5);
        for (int i = 0; i < gntLog.size() && i < 5; i++)
            checkOutput($sformatf("rrOrder%0d", i), gntLog[i], rrExp[i]);
        tick();

        // Core 2 read, request withdrawn during WAIT.
        applyStimulus(2, 1'b0, 16'h0022, 16'h0000);
        tick();
        checkOutput("wdGnt", gnt, 4'b0100);
        tick();
        req[2] = 1'b0;
        tick();
        tick();
        checkOutput("wdAck", ack, 4'b0100);
        checkOutput("wdData", rdata, 16'h22DD);
        tick();
        checkOutput("wdIdle1", busy, 0);
        tick();
        checkOutput("wdIdle2", busy, 0);

        // Pointer now at 3: cores 0 and 2 request, core 0 wins first.
        applyStimulus(0, 1'b1, 16'h0060, 16'hC000);
        applyStimulus(2, 1'b1, 16'h0062, 16'hC002);
        collectGrants(2, 1'b1, 30);
        req = '0;
        waitIdle(10);
        checkOutput("wrapCount", gntLog.size(), 2);
        if (gntLog.size() == 2) begin
            checkOutput("wrapFirst", gntLog[0], 4'b0001);
            checkOutput("wrapSecond", gntLog[1], 4'b0100);
        end
        tick();

        // Reset during WAIT of a core-1 read.
        applyStimulus(1, 1'b0, 16'h0033, 16'h0000);
        tick();
        checkOutput("rsGnt", gnt, 4'b0010);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rsGntZero", gnt, 0);
        checkOutput("rsAckZero", ack, 0);
        checkOutput("rsBusyZero", busy, 0);
        checkOutput("rsWrenZero", mem_wren, 0);
        checkOutput("rsAddrZero", mem_addr, 0);
        checkOutput("rsWdataZero", mem_wdata, 0);
        checkOutput("rsRdataZero", rdata, 0);
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("rsNoAck", ack, 0);
        // Cores 1 and 3: a reset pointer picks core 1, a stale pointer of 3 would pick core 3.
        applyStimulus(1, 1'b1, 16'h0071, 16'hD001);
        applyStimulus(3, 1'b1, 16'h0073, 16'hD003);
        collectGrants(2, 1'b1, 30);
        req = '0;
        waitIdle(10);
        checkOutput("rsCount", gntLog.size(), 2);
        if (gntLog.size() == 2) begin
            checkOutput("rsFirst", gntLog[0], 4'b0010);
            checkOutput("rsSecond", gntLog[1], 4'b1000);
        end
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
